overcurrent_guard: RTL

OVERCURRENT_GUARD -- requirements
Module: overcurrent_guard

---
 rtl/overcurrent_guard_if.sv | 24 ++
 rtl/overcurrent_guard.sv | 60 ++++++
 2 files changed

// File: rtl/overcurrent_guard_if.sv
// overcurrent_guard_if: sample, configuration and status bundle for overcurrent_guard.
interface overcurrent_guard_if #(
  parameter int ADC_WIDTH = 12,
  parameter int CH_NUM = 4
);
  logic s_valid;
  logic [CH_NUM*ADC_WIDTH-1:0] s_data;
  logic [CH_NUM*(ADC_WIDTH-1)-1:0] thr;
  logic [CH_NUM-1:0] protect_en;
  logic [3:0] trip_count;
  logic clear;
  logic [CH_NUM-1:0] trip;
  logic drv_en;
  logic irq;
  logic [CH_NUM*(ADC_WIDTH-1)-1:0] peak;
  modport master (
    output s_valid, s_data, thr, protect_en, trip_count, clear,
    input trip, drv_en, irq, peak
  );
  modport slave (
    input s_valid, s_data, thr, protect_en, trip_count, clear,
    output trip, drv_en, irq, peak
  );
endinterface

// File: rtl/overcurrent_guard.sv
// overcurrent_guard: per-channel overcurrent trip with consecutive-sample filter,
// latched trips gating the driver enable, and peak-magnitude capture.
module overcurrent_guard #(
  parameter int ADC_WIDTH = 12,
  parameter int CH_NUM = 4
) (
  input logic clk,
  input logic reset_n,
  overcurrent_guard_if.slave bus
);
  localparam int MW = ADC_WIDTH - 1;
  logic [CH_NUM*MW-1:0] mag_d, mag_q, peak_d, peak_q;
  logic [CH_NUM*4-1:0] cnt_d, cnt_q;
  logic [CH_NUM-1:0] trip_d, trip_q;
  logic mag_valid_q, drv_en_q, irq_q;
  logic [3:0] tc;
  // Offset-binary distance from mid-scale; full negative scale saturates to the largest magnitude.
  function automatic logic [MW-1:0] fmag(input logic [ADC_WIDTH-1:0] d);
    return d[ADC_WIDTH-1] ? d[MW-1:0] : (d == '0 ? '1 : MW'(-d[MW-1:0]));
  endfunction
  assign tc = bus.trip_count == 4'd0 ? 4'd1 : bus.trip_count;
  for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
    logic [MW-1:0] m, p;
    logic [3:0] c, inc;
    logic en, over;
    assign mag_d[k*MW +: MW] = fmag(bus.s_data[k*ADC_WIDTH +: ADC_WIDTH]);
    assign m = mag_q[k*MW +: MW];
    assign p = peak_q[k*MW +: MW];
    assign c = cnt_q[k*4 +: 4];
    assign en = bus.protect_en[k];
    assign over = en && m > bus.thr[k*MW +: MW];
    assign inc = c == 4'd15 ? c : c + 4'd1;
    assign cnt_d[k*4 +: 4] = bus.clear || !en ? 4'd0 : mag_valid_q ? (over ? inc : 4'd0) : c;
    assign trip_d[k] = !bus.clear && en && (trip_q[k] || (mag_valid_q && over && inc >= tc));
    assign peak_d[k*MW +: MW] = bus.clear ? '0 : (mag_valid_q && m > p ? m : p);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mag_q <= '0;
      mag_valid_q <= 1'b0;
      cnt_q <= '0;
      trip_q <= '0;
      peak_q <= '0;
      drv_en_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      if (bus.s_valid) mag_q <= mag_d;
      mag_valid_q <= bus.s_valid;
      cnt_q <= cnt_d;
      trip_q <= trip_d;
      peak_q <= peak_d;
      drv_en_q <= ~|trip_d;
      irq_q <= |(trip_d & ~trip_q);
    end
  end
  assign bus.trip = trip_q;
  assign bus.drv_en = drv_en_q;
  assign bus.irq = irq_q;
  assign bus.peak = peak_q;
endmodule
